// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The requester drives start and the operands; the adder returns status and result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: latches two operands and a carry-in, feeds one
// bit pair per clock (LSB first) through a single full-adder cell, and
// presents the parallel sum and carry-out with a one-cycle done strobe.

// Single-bit full-adder cell.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic [WIDTH-1:0] s_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  fulladder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .c  (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Sum register after this edge's shift: new sum bit enters at the MSB.
  generate
    if (WIDTH == 1) begin : g_one
      assign s_next = fa_s;
    end else begin : g_many
      assign s_next = {fa_s, s_sr[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Control FSM, datapath shift registers and registered outputs.
  // NOTE: every register here uses non-blocking assignment so all updates
  // take effect together at the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      s_sr     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_sr     <= bus.a;
            b_sr     <= bus.b;
            carry    <= bus.cin;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end else begin
            bus.busy <= 1'b0;
          end
        end
        SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          s_sr  <= s_next;
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            bus.sum  <= s_next;
            bus.cout <= fa_co;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed scenarios on an 8-bit
// instance plus exhaustive sweeps of 3-bit and 1-bit instances, all checked
// against plain integer addition.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bif8 ();
  serial_adder_if #(.WIDTH(3)) bif3 ();
  serial_adder_if #(.WIDTH(1)) bif1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bif8));
  serial_adder #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(bif3));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bif1));

  // Advance to just after the next rising edge (drive and sample point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {cout,sum} = a + b + cin for a given width.
  function automatic logic [32:0] ref_add(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin);
    logic [32:0] full;
    logic [32:0] mask;
    full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    mask = (33'd1 << (w + 1)) - 33'd1;
    return full & mask;
  endfunction

  // Run one 8-bit add starting at a sample point with the DUT idle. Operands
  // are scrambled right after the accepting edge; start is pulsed with junk
  // operands at sample indices inj1/inj2 (sample k is just after edge E_k).
  task automatic add8(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                      input int inj1, input int inj2,
                      output logic [7:0] os, output logic oc,
                      output int first_done, output int n_done, output int n_busy);
    bif8.start = 1'b1;
    bif8.a = ia;
    bif8.b = ib;
    bif8.cin = icin;
    tick();
    first_done = -1;
    n_done = 0;
    n_busy = 0;
    for (int k = 0; k <= 11; k++) begin
      if (k > 0) tick();
      if (bif8.done) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
      if (bif8.busy) n_busy++;
      bif8.a   = 8'($urandom);
      bif8.b   = 8'($urandom);
      bif8.cin = 1'($urandom);
      bif8.start = (k == inj1 || k == inj2);
    end
    bif8.start = 1'b0;
    os = bif8.sum;
    oc = bif8.cout;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif8.start = 1'b0; bif8.a = '0; bif8.b = '0; bif8.cin = 1'b0;
    bif3.start = 1'b0; bif3.a = '0; bif3.b = '0; bif3.cin = 1'b0;
    bif1.start = 1'b0; bif1.a = '0; bif1.b = '0; bif1.cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({bif8.busy, bif8.done, bif8.sum, bif8.cout} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_state8: got busy=%b done=%b sum=%h cout=%b, want all 0",
               bif8.busy, bif8.done, bif8.sum, bif8.cout);
    end
    n_checks++;
    if ({bif3.busy, bif3.done, bif3.sum, bif3.cout, bif1.busy, bif1.done, bif1.sum, bif1.cout} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_state_small: w3 busy=%b done=%b sum=%h cout=%b w1 busy=%b done=%b sum=%b cout=%b, want all 0",
               bif3.busy, bif3.done, bif3.sum, bif3.cout, bif1.busy, bif1.done, bif1.sum, bif1.cout);
    end
  endtask

  task automatic test_basic();
    logic [7:0] va [4] = '{8'h00, 8'hFF, 8'h7F, 8'hA5};
    logic [7:0] vb [4] = '{8'h00, 8'h01, 8'h01, 8'h5A};
    logic       vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] s;
    logic       c;
    logic [32:0] e;
    int fd, nd, nb;
    for (int i = 0; i < 4; i++) begin
      add8(va[i], vb[i], vc[i], -1, -1, s, c, fd, nd, nb);
      e = ref_add(8, 32'(va[i]), 32'(vb[i]), vc[i]);
      n_checks++;
      if ({c, s} !== e[8:0]) begin
        n_fail++;
        $display("FAIL basic_result[%0d]: got cout=%b sum=%h, want cout=%b sum=%h", i, c, s, e[8], e[7:0]);
      end
      n_checks++;
      if (fd !== 8 || nd !== 1) begin
        n_fail++;
        $display("FAIL basic_done_timing[%0d]: got first=%0d pulses=%0d, want first=8 pulses=1", i, fd, nd);
      end
      n_checks++;
      if (nb !== 9) begin
        n_fail++;
        $display("FAIL basic_busy_len[%0d]: got %0d, want 9", i, nb);
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [7:0] s;
    logic       c;
    int fd, nd, nb;
    // Junk start during SHIFT (k=4) and during DONE (k=8).
    add8(8'h3C, 8'hC5, 1'b1, 4, 8, s, c, fd, nd, nb);
    n_checks++;
    if ({c, s} !== 9'h102) begin
      n_fail++;
      $display("FAIL busy_ignore_result: got cout=%b sum=%h, want cout=1 sum=02", c, s);
    end
    n_checks++;
    if (fd !== 8 || nd !== 1 || nb !== 9) begin
      n_fail++;
      $display("FAIL busy_ignore_timing: got first=%0d pulses=%0d busy=%0d, want 8/1/9", fd, nd, nb);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] s;
    logic       c;
    int fd, nd, nb;
    int extra;
    add8(8'h12, 8'h01, 1'b0, -1, -1, s, c, fd, nd, nb);
    bif8.start = 1'b1; bif8.a = 8'h55; bif8.b = 8'h66; bif8.cin = 1'b1;
    tick();
    bif8.start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (bif8.busy !== 1'b0 || bif8.done !== 1'b0 || bif8.sum !== 8'h00 || bif8.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset_clear: got busy=%b done=%b sum=%h cout=%b, want 0/0/00/0",
               bif8.busy, bif8.done, bif8.sum, bif8.cout);
    end
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bif8.done) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL midop_no_done: got %0d done pulses, want 0", extra);
    end
    add8(8'h12, 8'h34, 1'b0, -1, -1, s, c, fd, nd, nb);
    n_checks++;
    if ({c, s} !== 9'h046 || fd !== 8) begin
      n_fail++;
      $display("FAIL midop_recover: got cout=%b sum=%h first_done=%0d, want cout=0 sum=46 first_done=8", c, s, fd);
    end
  endtask

  task automatic test_back_to_back();
    int done_at [$];
    logic [7:0] sum_pre2;
    logic       busy9, busy10;
    bif8.start = 1'b1; bif8.a = 8'h10; bif8.b = 8'h20; bif8.cin = 1'b0;
    tick();
    bif8.a = 8'hF0;
    sum_pre2 = 8'hxx;
    busy9 = 1'bx;
    busy10 = 1'bx;
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (bif8.done) done_at.push_back(k);
      if (k == 9) busy9 = bif8.busy;
      if (k == 10) busy10 = bif8.busy;
      if (k == 17) sum_pre2 = bif8.sum;
      if (k == 18) bif8.start = 1'b0;
    end
    n_checks++;
    if (done_at.size() != 2 || done_at[0] != 8 || done_at[1] != 18) begin
      n_fail++;
      $display("FAIL b2b_done_edges: got %0d pulses first=%0d, want pulses at 8 and 18",
               done_at.size(), (done_at.size() > 0) ? done_at[0] : -1);
    end
    n_checks++;
    if (busy9 !== 1'b0 || busy10 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept_period: got busy@9=%b busy@10=%b, want 0 then 1", busy9, busy10);
    end
    n_checks++;
    if (sum_pre2 !== 8'h30) begin
      n_fail++;
      $display("FAIL b2b_sum_hold: got %h, want 30", sum_pre2);
    end
    n_checks++;
    if (bif8.sum !== 8'h10 || bif8.cout !== 1'b1 || bif8.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_result: got sum=%h cout=%b busy=%b, want 10/1/0", bif8.sum, bif8.cout, bif8.busy);
    end
  endtask

  task automatic test_random();
    logic [7:0] ra, rb, s;
    logic       rc, c;
    logic [32:0] e;
    int fd, nd, nb;
    int bad;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      add8(ra, rb, rc, -1, -1, s, c, fd, nd, nb);
      e = ref_add(8, 32'(ra), 32'(rb), rc);
      n_checks++;
      if ({c, s} !== e[8:0] || fd !== 8) begin
        n_fail++;
        $display("FAIL random8[%0d] %h+%h+%b: got cout=%b sum=%h first_done=%0d, want cout=%b sum=%h first_done=8",
                 i, ra, rb, rc, c, s, fd, e[8], e[7:0]);
      end
    end
  endtask

  task automatic test_exhaustive_w3();
    logic [32:0] e;
    int fd, nd;
    for (int ia = 0; ia < 8; ia++)
      for (int ib = 0; ib < 8; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          bif3.start = 1'b1; bif3.a = 3'(ia); bif3.b = 3'(ib); bif3.cin = 1'(ic);
          tick();
          bif3.start = 1'b0; bif3.a = 3'($urandom); bif3.b = 3'($urandom); bif3.cin = 1'($urandom);
          fd = -1;
          nd = 0;
          for (int k = 1; k <= 5; k++) begin
            tick();
            if (bif3.done) begin
              nd++;
              if (fd < 0) fd = k;
            end
          end
          e = ref_add(3, 32'(ia), 32'(ib), 1'(ic));
          n_checks++;
          if ({bif3.cout, bif3.sum} !== e[3:0] || fd !== 3 || nd !== 1) begin
            n_fail++;
            $display("FAIL exh3 %0d+%0d+%0d: got cout=%b sum=%0d first_done=%0d pulses=%0d, want cout=%b sum=%0d first_done=3 pulses=1",
                     ia, ib, ic, bif3.cout, bif3.sum, fd, nd, e[3], e[2:0]);
          end
        end
  endtask

  task automatic test_exhaustive_w1();
    logic [32:0] e;
    int fd, nd;
    for (int ia = 0; ia < 2; ia++)
      for (int ib = 0; ib < 2; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          bif1.start = 1'b1; bif1.a = 1'(ia); bif1.b = 1'(ib); bif1.cin = 1'(ic);
          tick();
          bif1.start = 1'b0; bif1.a = 1'($urandom); bif1.b = 1'($urandom); bif1.cin = 1'($urandom);
          fd = -1;
          nd = 0;
          for (int k = 1; k <= 3; k++) begin
            tick();
            if (bif1.done) begin
              nd++;
              if (fd < 0) fd = k;
            end
          end
          e = ref_add(1, 32'(ia), 32'(ib), 1'(ic));
          n_checks++;
          if ({bif1.cout, bif1.sum} !== e[1:0] || fd !== 1 || nd !== 1) begin
            n_fail++;
            $display("FAIL exh1 %0d+%0d+%0d: got cout=%b sum=%b first_done=%0d pulses=%0d, want cout=%b sum=%b first_done=1 pulses=1",
                     ia, ib, ic, bif1.cout, bif1.sum, fd, nd, e[1], e[0]);
          end
        end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    test_exhaustive_w3();
    test_exhaustive_w1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around the team's existing single-bit `fulladder` cell. It is the stage directly upstream of that cell. It latches two parallel operands and a carry-in, then feeds the cell one bit pair per clock, LSB first. It registers the cell's carry output back into the cell's `c` input and shifts the cell's sum bits into a result register. It presents a parallel sum and carry-out with a one-cycle `done` strobe.

## Interface
- `WIDTH`, default 8: operand and sum width in bits. Legal range is 1 to 32.

- `clk`, input, 1: the only clock. All state changes on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request to begin an addition. Sampled only in IDLE.
- `a`, input, WIDTH: operand A. Captured on the accepted `start` edge.
- `b`, input, WIDTH: operand B. Captured on the accepted `start` edge.
- `cin`, input, 1: carry-in. Captured on the accepted `start` edge.
- `busy`, output, 1: high in SHIFT and DONE.
- `done`, output, 1: one-cycle strobe; `sum`/`cout` are new this cycle.
- `sum`, output, WIDTH: result of the most recent completed addition.
- `cout`, output, 1: carry-out of the most recent completed addition.

## Operation
- There is exactly one `fulladder` instance:
  - `a` input = `a_sr[0]`
  - `b` input = `b_sr[0]`
  - `c` input = carry register
- Internal state:
  - `a_sr`, `b_sr`, `s_sr`: WIDTH-bit shift registers.
  - Carry register: 1 bit.
  - Bit counter: wide enough to hold WIDTH.
  - FSM: IDLE, SHIFT, DONE.
- IDLE:
  - On `start`=1: load `a_sr`=`a`, `b_sr`=`b`, carry=`cin`, counter=0; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, every edge:
  - `a_sr`, `b_sr` shift right by 1, with 0 entering the MSB.
  - `s_sr` shifts right by 1, with the cell's sum entering `s_sr[WIDTH-1]`.
  - Carry register takes the cell's carry output.
  - Counter increments.
  - On the edge where the counter equals WIDTH-1: also load `sum` from the shifted value of `s_sr` (including that edge's sum bit), load `cout` from the cell's carry, and go to DONE.
- DONE: `done`=1 for this one cycle, then unconditionally go to IDLE.
- `start` is ignored in SHIFT and DONE. A start is never queued.
- `sum`/`cout` change only on the edge entering DONE, and hold between completions.
- Arithmetic: {`cout`,`sum`} = `a` + `b` + `cin`, computed modulo 2^(WIDTH+1).

## Timing
- Reset values (`rst`=1 at an edge):
  - State = IDLE.
  - `busy`=0, `done`=0, `sum`=0, `cout`=0.
  - All shift registers, carry register and counter = 0.
- `rst` has priority over `start` and over all FSM activity.
- Reset during SHIFT or DONE aborts the operation: no `done` pulse, and `sum`/`cout` are cleared.
- Latency, with `start` accepted at edge E0:
  - `busy` rises after E0.
  - Edges E1 through E_WIDTH process bits 0 through WIDTH-1.
  - `done`=1 and new `sum`/`cout` are visible in the cycle after E_WIDTH.
  - `busy` and `done` fall after E_(WIDTH+1).
- Throughput: the next `start` can be accepted at E_(WIDTH+2). That gives one addition per WIDTH+2 cycles.
- WIDTH=1: exactly one SHIFT cycle; `done` is visible after E1.
- `a`, `b`, `cin` may change freely after E0 without affecting the result.
- `done` and `busy` are registered outputs, not combinational from inputs.

## Test plan
- Basic add: WIDTH=8, `a`=0x00, `b`=0x00, `cin`=0 -> `sum`=0x00, `cout`=0.
  - `done` is visible exactly 9 cycles after the start-accepting edge's cycle and lasts 1 cycle.
  - `busy` is high for 9 cycles.
- Carry ripple: `a`=0xFF, `b`=0x01, `cin`=0 -> `sum`=0x00, `cout`=1.
  - `a`=0x7F, `b`=0x01, `cin`=0 -> `sum`=0x80, `cout`=0.
  - `a`=0xA5, `b`=0x5A, `cin`=1 -> `sum`=0x00, `cout`=1.
- Start while busy: pulse `start` with new operands in the middle of SHIFT and again during DONE.
  - Both requests are ignored; the result matches the original operands.
  - No extra `done` pulse occurs.
  - Operands are changed right after E0 and the result is still correct.
- Reset mid-operation: assert `rst` at bit 4 of an 8-bit add.
  - Next cycle: `busy`=0, `sum`=0, `cout`=0; no `done` follows.
  - A subsequent add of 0x12 + 0x34 gives 0x46 with `cout`=0.
- Back-to-back: hold `start`=1 continuously with 0x10 + 0x20, then 0xF0 + 0x20.
  - Each new addition is accepted every 10 cycles.
  - `sum` holds 0x30 until the second `done`, then becomes 0x10 with `cout`=1.
- Exhaustive: WIDTH=3 and WIDTH=1, all `a`, `b`, `cin` combinations.
  - Each result is compared against `a` + `b` + `cin`.
  - Each run also checks `done` timing at WIDTH+1 edges.
